// File: rtl/machine_timer_pkg.sv
// Shared definitions for machine_timer: register offsets, CTRL bit positions,
// interrupt bit position and default widths.
package machine_timer_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int INT_W_DEF      = 8;
    localparam int ADDR_LSB_W_DEF = 4;
    localparam int ADDR_W         = 32;
    localparam int PRESC_W        = 16;

    localparam logic [3:0] TMR_CTRL  = 4'h0;
    localparam logic [3:0] TMR_COUNT = 4'h4;
    localparam logic [3:0] TMR_LIMIT = 4'h8;
    localparam logic [3:0] TMR_PRESC = 4'hC;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_PEND = 2;

    localparam int INT_TIMER0 = 0;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_COUNT,
        SEL_LIMIT,
        SEL_PRESC
    } reg_sel_e;

    // Field order matches the CTRL bit indices above (en is bit 0).
    typedef struct packed {
        logic pend;
        logic ie;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/machine_timer_if.sv
// Single-requester peripheral bus: one-cycle req_i, registered one-cycle ack_o
// carrying read data.
interface machine_timer_if #(
    parameter int CNT_W = 32
);
    logic             req_i;
    logic             we_i;
    logic [31:0]      addr_i;
    logic [CNT_W-1:0] data_i;
    logic [CNT_W-1:0] data_o;
    logic             ack_o;

    modport master (output req_i, we_i, addr_i, data_i, input data_o, ack_o);
    modport slave  (input req_i, we_i, addr_i, data_i, output data_o, ack_o);
endinterface

// File: rtl/timer_prescaler.sv
// Tick divider for machine_timer; present only when MACHINE_TIMER_PRESCALER_EN
// is defined. Emits one tick every PRESC+1 enabled cycles.
`ifdef MACHINE_TIMER_PRESCALER_EN
module timer_prescaler
    import machine_timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);
    logic [PRESC_W-1:0] div_q, div_d;

    assign tick_o = en_i && (div_q == presc_i);

    always_comb begin
        if (!en_i || clr_i || tick_o) div_d = '0;
        else                          div_d = div_q + PRESC_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div_q <= '0;
        else      div_q <= div_d;
    end
endmodule
`endif

// File: rtl/machine_timer.sv
// Core-local machine timer: COUNT/LIMIT compare raising int_flag_o[INT_TIMER0].
// Defining MACHINE_TIMER_PRESCALER_EN adds the PRESC register and tick divider.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int INT_W      = INT_W_DEF,
    parameter int ADDR_LSB_W = ADDR_LSB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    machine_timer_if.slave   bus,
    output logic [INT_W-1:0] int_flag_o
);
    reg_sel_e              sel;
    logic [ADDR_LSB_W-1:0] offset;
    logic                  unused_addr;
    logic                  wr, rd, ctrl_wr, count_wr, limit_wr;
    logic                  tick, match;
    logic [CNT_W-1:0]      presc_rd, rd_val;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [CNT_W-1:0]      count_q, count_d, limit_q, limit_d, rdata_q, rdata_d;
    logic                  ack_q, irq_q, irq_d;

    assign offset      = bus.addr_i[ADDR_LSB_W-1:0];
    assign unused_addr = ^bus.addr_i[ADDR_W-1:ADDR_LSB_W];

    always_comb begin
        sel = SEL_NONE;
        if      (offset == ADDR_LSB_W'(TMR_CTRL))  sel = SEL_CTRL;
        else if (offset == ADDR_LSB_W'(TMR_COUNT)) sel = SEL_COUNT;
        else if (offset == ADDR_LSB_W'(TMR_LIMIT)) sel = SEL_LIMIT;
        else if (offset == ADDR_LSB_W'(TMR_PRESC)) sel = SEL_PRESC;
    end

    assign wr       = bus.req_i && bus.we_i;
    assign rd       = bus.req_i && !bus.we_i;
    assign ctrl_wr  = wr && (sel == SEL_CTRL);
    assign count_wr = wr && (sel == SEL_COUNT);
    assign limit_wr = wr && (sel == SEL_LIMIT);

`ifdef MACHINE_TIMER_PRESCALER_EN
    logic               presc_wr;
    logic [PRESC_W-1:0] presc_q, presc_d;

    assign presc_wr = wr && (sel == SEL_PRESC);
    assign presc_d  = presc_wr ? bus.data_i[PRESC_W-1:0] : presc_q;
    assign presc_rd = CNT_W'(presc_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) presc_q <= '0;
        else      presc_q <= presc_d;
    end

    // Any CTRL write (including EN changes) restarts the divider phase.
    timer_prescaler u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ctrl_q.en),
        .clr_i   (ctrl_wr || presc_wr),
        .presc_i (presc_q),
        .tick_o  (tick)
    );
`else
    assign tick     = ctrl_q.en;
    assign presc_rd = '0;
`endif

    // NOTE: every signal written here gets a value on every path, so no latches.
    always_comb begin
        match = tick && (count_q == limit_q) && !count_wr;

        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d.en = bus.data_i[CTRL_EN];
            ctrl_d.ie = bus.data_i[CTRL_IE];
            if (bus.data_i[CTRL_PEND]) ctrl_d.pend = 1'b0;
        end
        if (match) ctrl_d.pend = 1'b1;

        if      (count_wr) count_d = bus.data_i;
        else if (match)    count_d = '0;
        else if (tick)     count_d = count_q + CNT_W'(1);
        else               count_d = count_q;

        limit_d = limit_wr ? bus.data_i : limit_q;

        case (sel)
            SEL_CTRL:  rd_val = CNT_W'(ctrl_q);
            SEL_COUNT: rd_val = count_q;
            SEL_LIMIT: rd_val = limit_q;
            SEL_PRESC: rd_val = presc_rd;
            default:   rd_val = '0;
        endcase
        rdata_d = rd ? rd_val : '0;

        irq_d = ctrl_q.pend && ctrl_q.ie;
    end

    // NOTE: non-blocking updates so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            count_q <= '0;
            limit_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            limit_q <= limit_d;
            rdata_q <= rdata_d;
            ack_q   <= bus.req_i;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        int_flag_o             = '0;
        int_flag_o[INT_TIMER0] = irq_q;
    end

    assign bus.ack_o  = ack_q;
    assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: hand-derived vector table, corner-case
// sequences and a randomized run scored against a cycle-level register model.
module tb_machine_timer;
    import machine_timer_pkg::*;

    localparam int CW = CNT_W_DEF;
    localparam int IW = INT_W_DEF;
    localparam logic [31:0] A_CTRL  = 32'(TMR_CTRL);
    localparam logic [31:0] A_COUNT = 32'(TMR_COUNT);
    localparam logic [31:0] A_LIMIT = 32'(TMR_LIMIT);
    localparam logic [31:0] A_PRESC = 32'(TMR_PRESC);
`ifdef MACHINE_TIMER_PRESCALER_EN
    localparam bit HAS_PRESC = 1'b1;
`else
    localparam bit HAS_PRESC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] int_flag;
    int            n_checks = 0;
    int            n_fail   = 0;

    machine_timer_if #(.CNT_W(CW)) bus ();

    machine_timer #(.CNT_W(CW), .INT_W(IW), .ADDR_LSB_W(ADDR_LSB_W_DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .int_flag_o (int_flag)
    );

    always #5 clk = ~clk;

    // Reference model state: the programmer-visible registers plus the divider.
    bit          m_en, m_ie, m_pend, m_ack, m_int;
    logic [31:0] m_count, m_limit, m_rdata;
    logic [15:0] m_presc, m_div;

    typedef struct packed {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_ack;
        logic [31:0] exp_rdata;
        bit          exp_int;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        {m_en, m_ie, m_pend, m_ack, m_int} = '0;
        m_count = '0; m_limit = '0; m_rdata = '0; m_presc = '0; m_div = '0;
    endtask

    // One clock of the register-level rules, all evaluated on pre-edge state.
    task automatic model_step(input bit req, input bit we, input logic [31:0] addr,
                              input logic [31:0] wd);
        logic [3:0]  off;
        logic [31:0] rv;
        bit          wr, tick, hit, ctrl_w, presc_w, cnt_w;
        off     = addr[3:0];
        wr      = req && we;
        ctrl_w  = wr && (off == TMR_CTRL);
        cnt_w   = wr && (off == TMR_COUNT);
        presc_w = wr && (off == TMR_PRESC);
        if      (off == TMR_CTRL)  rv = {29'b0, m_pend, m_ie, m_en};
        else if (off == TMR_COUNT) rv = m_count;
        else if (off == TMR_LIMIT) rv = m_limit;
        else if (off == TMR_PRESC) rv = HAS_PRESC ? {16'b0, m_presc} : 32'b0;
        else                       rv = 32'b0;
        tick = HAS_PRESC ? (m_en && (m_div == m_presc)) : m_en;
        hit  = tick && (m_count == m_limit) && !cnt_w;

        m_rdata = (req && !we) ? rv : 32'b0;
        m_ack   = req;
        m_int   = m_pend && m_ie;
        if (HAS_PRESC) m_div = (!m_en || ctrl_w || presc_w || tick) ? 16'd0 : m_div + 16'd1;
        if (cnt_w)      m_count = wd;
        else if (hit)   m_count = 32'd0;
        else if (tick)  m_count = m_count + 32'd1;
        if (ctrl_w && wd[CTRL_PEND]) m_pend = 1'b0;
        if (hit)                     m_pend = 1'b1;
        if (ctrl_w) begin
            m_en = wd[CTRL_EN];
            m_ie = wd[CTRL_IE];
        end
        if (wr && off == TMR_LIMIT) m_limit = wd;
        if (presc_w && HAS_PRESC)   m_presc = wd[PRESC_W-1:0];
    endtask

    task automatic compare_model(input string tag);
        logic [IW-1:0] ei;
        ei             = '0;
        ei[INT_TIMER0] = m_int;
        check({tag, "_ack"},   32'(bus.ack_o), 32'(m_ack));
        check({tag, "_rdata"}, bus.data_o,     m_rdata);
        check({tag, "_int"},   32'(int_flag),  32'(ei));
    endtask

    // Drive one bus cycle, let the edge happen, then score against the model.
    task automatic op(input string tag, input bit req, input bit we,
                      input logic [31:0] addr, input logic [31:0] data);
        bus.req_i = req; bus.we_i = we; bus.addr_i = addr; bus.data_i = data;
        @(posedge clk); #1;
        model_step(req, we, addr, data);
        bus.req_i = 1'b0; bus.we_i = 1'b0;
        compare_model(tag);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        op("wr", 1'b1, 1'b1, a, d);
    endtask

    task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        op(tag, 1'b1, 1'b0, a, 32'b0);
        check({tag, "_exp"}, bus.data_o, exp);
    endtask

    task automatic idle();
        op("idle", 1'b0, 1'b0, 32'b0, 32'b0);
    endtask

    // Reset asserted between edges while a read acknowledge is on the bus.
    task automatic reset_mid_op(input string tag);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = A_COUNT;
        @(posedge clk); #1;
        model_step(1'b1, 1'b0, A_COUNT, 32'b0);
        bus.req_i = 1'b0;
        compare_model({tag, "_pre"});
        check({tag, "_ack_inflight"}, 32'(bus.ack_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        check({tag, "_ack_dropped"}, 32'(bus.ack_o), 32'd0);
        check({tag, "_rdata_zero"},  bus.data_o,     32'd0);
        check({tag, "_int_zero"},    32'(int_flag),  32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        rd_reg({tag, "_count"}, A_COUNT, 32'd0);
        rd_reg({tag, "_ctrl"},  A_CTRL,  32'd0);
        rd_reg({tag, "_limit"}, A_LIMIT, 32'd0);
    endtask

    task automatic random_phase(input int n);
        bit          rq, w;
        int          k;
        logic [31:0] a, d;
        for (int i = 0; i < n; i++) begin
            rq = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            k  = $urandom_range(0, 4);
            case (k)
                0:       a = A_CTRL;
                1:       a = A_COUNT;
                2:       a = A_LIMIT;
                3:       a = A_PRESC;
                default: a = $urandom;
            endcase
            case (k)
                0: d = 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 3) != 0);
                1: d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 8))
                                                   : 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                2: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 8));
                3: d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 2));
                default: d = $urandom;
            endcase
            op($sformatf("rnd%0d", i), rq, w, a, d);
        end
    endtask

    function automatic vec_t mk(bit req, bit we, logic [31:0] a, logic [31:0] d,
                                bit ea, logic [31:0] ed, bit ei);
        vec_t v;
        v = '{req: req, we: we, addr: a, wdata: d, exp_ack: ea, exp_rdata: ed, exp_int: ei};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(bus.ack_o), 32'd0);
        check("rst_rdata", bus.data_o,     32'd0);
        check("rst_int",   32'(int_flag),  32'd0);
        rst = 1'b1;

        // Reset reads, periodic match with LIMIT=4, PEND/IE handling, decode holes.
        vecs.push_back(mk(1, 0, A_CTRL,  0, 1, 0, 0));
        vecs.push_back(mk(1, 0, A_COUNT, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, A_LIMIT, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, A_PRESC, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(1, 1, A_LIMIT, 4, 1, 0, 0));
        vecs.push_back(mk(1, 1, A_CTRL,  3, 1, 0, 0));
        vecs.push_back(mk(1, 0, A_COUNT, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, A_COUNT, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, A_COUNT, 0, 1, 2, 0));
        vecs.push_back(mk(1, 0, A_COUNT, 0, 1, 3, 0));
        vecs.push_back(mk(1, 0, A_COUNT, 0, 1, 4, 0));
        vecs.push_back(mk(1, 0, A_COUNT, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, A_CTRL,  0, 1, 7, 1));
        vecs.push_back(mk(1, 1, A_CTRL,  3, 1, 0, 1));
        vecs.push_back(mk(1, 1, A_CTRL,  1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(1, 0, A_CTRL,  0, 1, 5, 0));
        vecs.push_back(mk(1, 1, A_CTRL,  4, 1, 0, 0));
        vecs.push_back(mk(1, 0, A_CTRL,  0, 1, 0, 0));
        vecs.push_back(mk(1, 0, A_COUNT, 0, 1, 2, 0));
        vecs.push_back(mk(1, 1, 32'h6,   32'hFFFF, 1, 0, 0));
        vecs.push_back(mk(1, 0, A_LIMIT, 0, 1, 4, 0));
        vecs.push_back(mk(1, 0, 32'h3,   0, 1, 0, 0));
        foreach (vecs[i]) begin
            op($sformatf("vec%0d", i), vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_ack_tbl", i),   32'(bus.ack_o), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_rdata_tbl", i), bus.data_o,     vecs[i].exp_rdata);
            check($sformatf("vec%0d_int_tbl", i),   32'(int_flag[INT_TIMER0]), 32'(vecs[i].exp_int));
        end

        // Clear and match in the same cycle: set wins; a clear without match drops the flag.
        wr_reg(A_LIMIT, 2); wr_reg(A_COUNT, 0); wr_reg(A_CTRL, 3);
        idle(); idle();
        wr_reg(A_CTRL, 7);
        rd_reg("clrprio_pend", A_CTRL, 7);
        wr_reg(A_CTRL, 7);
        idle();
        check("clrprio_int_low", 32'(int_flag[INT_TIMER0]), 32'd0);
        wr_reg(A_CTRL, 4);

        // COUNT write beats a same-cycle match.
        wr_reg(A_LIMIT, 9); wr_reg(A_COUNT, 9); wr_reg(A_CTRL, 1);
        wr_reg(A_COUNT, 2);
        rd_reg("cntwr_pend", A_CTRL, 1);
        rd_reg("cntwr_count", A_COUNT, 3);
        wr_reg(A_CTRL, 4);

        // LIMIT below COUNT: wrap without PEND; back-to-back reads.
        wr_reg(A_LIMIT, 5); wr_reg(A_COUNT, 32'hFFFF_FFFE); wr_reg(A_CTRL, 3);
        rd_reg("wrap0", A_COUNT, 32'hFFFF_FFFE);
        rd_reg("wrap1", A_COUNT, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            rd_reg($sformatf("wrap_n%0d", i), A_COUNT, 32'(i));
            check($sformatf("wrap_n%0d_ack", i), 32'(bus.ack_o), 32'd1);
            check($sformatf("wrap_n%0d_int", i), 32'(int_flag[INT_TIMER0]), 32'd0);
        end
        rd_reg("wrap_pend", A_CTRL, 7);
        wr_reg(A_CTRL, 4);

        // All-ones COUNT == LIMIT matches instead of wrapping.
        wr_reg(A_LIMIT, 32'hFFFF_FFFF); wr_reg(A_COUNT, 32'hFFFF_FFFF); wr_reg(A_CTRL, 1);
        rd_reg("ones_count", A_COUNT, 32'hFFFF_FFFF);
        rd_reg("ones_pend",  A_CTRL,  5);
        rd_reg("ones_after", A_COUNT, 1);
        wr_reg(A_CTRL, 4);

        // LIMIT = 0 holds COUNT at 0; clearing EN keeps PEND and freezes COUNT.
        wr_reg(A_LIMIT, 0); wr_reg(A_COUNT, 0); wr_reg(A_CTRL, 1);
        rd_reg("lim0_a", A_COUNT, 0);
        rd_reg("lim0_b", A_COUNT, 0);
        rd_reg("lim0_pend", A_CTRL, 5);
        wr_reg(A_CTRL, 0);
        rd_reg("endis_pend", A_CTRL, 4);
        rd_reg("endis_count", A_COUNT, 0);

        // PRESC register: functional with the prescaler, otherwise reads 0.
        wr_reg(A_CTRL, 3);
        idle();
        reset_mid_op("rst1");
        wr_reg(A_PRESC, 3);
        rd_reg("presc_rb", A_PRESC, HAS_PRESC ? 32'd3 : 32'd0);
`ifdef MACHINE_TIMER_PRESCALER_EN
        wr_reg(A_LIMIT, 1); wr_reg(A_CTRL, 3);
        repeat (7) idle();
        rd_reg("presc_nomatch", A_CTRL, 3);
        rd_reg("presc_match",   A_CTRL, 7);
        repeat (5) idle();
        reset_mid_op("rst2");
        rd_reg("presc_reset", A_PRESC, 0);
`endif

        random_phase(3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- Memory-mapped core-local timer on the peripheral bus. It is the upstream source of the `int_flag_i` vector consumed by the core-local interrupt controller.
- It counts enabled ticks and compares the count against a software-programmed limit.
- On a match it latches a pending bit and drives interrupt bit 0 (timer) until software clears it.
- Reads and writes arrive over a single-requester bus handshake.

Parameters:
- CNT_W, 32, width of COUNT, LIMIT and bus data.
- INT_W, 8, width of the interrupt flag vector; must equal the core `INT_BUS` width.
- ADDR_LSB_W, 4, number of low address bits decoded for register select.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  1  bus access request, single cycle.
- we_i  in  1  1 = write, 0 = read; qualified by req_i.
- addr_i  in  32  byte address; only [ADDR_LSB_W-1:0] decoded.
- data_i  in  CNT_W  write data.
- data_o  out  CNT_W  read data, valid when ack_o = 1.
- ack_o  out  1  one-cycle acknowledge.
- int_flag_o  out  INT_W  interrupt vector; bit0 = timer, other bits constant 0.

Behaviour:
- Register map:
  - 0x0 CTRL: bit0 EN (count enable); bit1 IE (interrupt enable); bit2 PEND, read-only status, write 1 to clear; other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 LIMIT: read/write.
  - 0xC PRESC: see Optional Feature.
  - Any other offset: reads 0, writes ignored, still acknowledged.
- Reset (rst low, asynchronous): CTRL, COUNT and LIMIT = 0; data_o = 0; ack_o = 0; int_flag_o = 0.
- Bus handshake:
  - req_i sampled on a rising clk; ack_o asserts exactly the following cycle for exactly one cycle.
  - For a read, data_o carries the register value as sampled at the req_i edge, held only while ack_o = 1, otherwise 0.
  - Writes take effect at the req_i edge.
  - Back-to-back requests on consecutive cycles are all accepted, with ack_o high continuously.
- Tick: when EN = 1, tick = 1 every clk (without the optional feature).
- Counting, per cycle, highest priority first:
  1. Bus write to COUNT: COUNT <= data_i. Any match this cycle is suppressed.
  2. tick and COUNT == LIMIT: COUNT <= 0 and PEND <= 1 (match event).
  3. tick: COUNT <= COUNT + 1, modulo 2^CNT_W.
  4. Otherwise COUNT holds.
- Boundary cases:
  - LIMIT = 0 with EN = 1: COUNT stays 0 and a match occurs every tick.
  - LIMIT written below the current COUNT: COUNT runs up to all-ones, wraps to 0 with no PEND, then matches normally.
  - COUNT == all-ones == LIMIT: a match occurs, not a wrap.
- PEND:
  - Set by a match, cleared by a CTRL write with data_i[2] = 1.
  - Set and clear in the same cycle: set wins, PEND = 1.
  - A CTRL write with data_i[2] = 0 leaves PEND unchanged.
- EN cleared: COUNT freezes, PEND is retained.
- int_flag_o[0] is registered: it equals PEND & IE with a 1-cycle delay.
  - It stays asserted until cleared.
  - Clearing IE deasserts it one cycle later; PEND is kept.
- Reset mid-operation: everything returns to reset values immediately; an in-flight ack is dropped.

Optional Feature:
- Macro: MACHINE_TIMER_PRESCALER_EN.
- Defined:
  - PRESC register at 0xC, 16 bits, reset 0.
  - A 16-bit divider counter runs while EN = 1. It produces tick = 1 when divider == PRESC, then resets to 0. PRESC = 0 therefore gives a tick every cycle.
  - A write to PRESC or CTRL resets the divider to 0.
  - Clearing EN resets the divider.
- Not defined:
  - 0xC reads 0 and ignores writes.
  - tick = EN.

Decomposition:
- Shared defines header (same as the bus/core defines):
  - register offsets TMR_CTRL, TMR_COUNT, TMR_LIMIT, TMR_PRESC;
  - CTRL bit indices;
  - INT_TIMER0 bit position.
- One natural sub-module, timer_prescaler, holding the divider and tick generation; it exists only under the macro.
- Bus decode and the counter stay in machine_timer.

Test Plan:
- Reset check: hold rst low 3 cycles, then release → all reads return 0, int_flag_o = 0, ack_o = 0.
- Periodic match: LIMIT = 4, CTRL = 0x3 → int_flag_o[0] rises 1 cycle after the 5th tick after enable. COUNT sequence reads 0,1,2,3,4,0.
- Clear priority: write CTRL = 0x7 on the same cycle as a match → PEND remains 1. A later write of 0x7 with no match → int_flag_o[0] = 0 one cycle later.
- COUNT write vs match: COUNT == LIMIT = 9 and a write COUNT = 2 in the same cycle → COUNT = 2, PEND stays 0.
- Wrap: LIMIT = 5, COUNT = 0xFFFF_FFFE, EN = 1 → COUNT goes 0xFFFF_FFFF, 0, …, 5, match; no PEND at the wrap. Back-to-back reads get ack_o high on consecutive cycles.
- With MACHINE_TIMER_PRESCALER_EN: PRESC = 3, LIMIT = 1 → match every 8 clocks. Asynchronous reset asserted mid-count → COUNT = 0 immediately.
